// File: rtl/spi_frame_acc_pkg.sv
// Shared types for the SPI frame accumulator: collection FSM states and the
// frame-length width helper.
package spi_acc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        DISCARD = 2'd2
    } state_e;

    // Width of a byte counter that must hold 0..max_bytes inclusive.
    function automatic int unsigned len_w(input int unsigned max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

endpackage

// File: rtl/spi_frame_acc_out_reg.sv
// Valid/ready output register for completed frames; flags a frame that
// arrives while the held frame is still waiting to be accepted.
module spi_acc_out_reg #(
    parameter int unsigned AW = 64,
    parameter int unsigned LW = 4
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          pub_valid_i,
    input  logic [AW-1:0] pub_bytes_i,
    input  logic [LW-1:0] pub_len_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [AW-1:0] bytes_o,
    output logic [LW-1:0] len_o,
    output logic          drop_o
);

    logic          valid_q, valid_d;
    logic [AW-1:0] bytes_q, bytes_d;
    logic [LW-1:0] len_q,   len_d;
    logic          drop_q,  drop_d;
    logic          can_load;

    assign can_load = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        bytes_d = bytes_q;
        len_d   = len_q;
        drop_d  = 1'b0;
        if (pub_valid_i && can_load) begin
            valid_d = 1'b1;
            bytes_d = pub_bytes_i;
            len_d   = pub_len_i;
        end else if (pub_valid_i) begin
            drop_d  = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            valid_q <= 1'b0;
            bytes_q <= '0;
            len_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            bytes_q <= bytes_d;
            len_q   <= len_d;
            drop_q  <= drop_d;
        end
    end

    assign valid_o = valid_q;
    assign bytes_o = bytes_q;
    assign len_o   = len_q;
    assign drop_o  = drop_q;

endmodule

// File: rtl/spi_frame_acc.sv
// Collects SPI bytes into chip-select delimited frames and publishes them.
// Optional inter-byte timeout abort is built when SPI_ACC_TIMEOUT_EN is defined.
module spi_frame_acc
    import spi_acc_pkg::*;
#(
    parameter int unsigned MAX_BYTES      = 8,
    parameter int unsigned MIN_BYTES      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rst_,
    input  logic [7:0]                     i_RX_Byte,
    input  logic                           i_RX_DV,
    input  logic                           i_CS_n,
    output logic                           o_Acc_DV,
    input  logic                           i_Acc_Ready,
    output logic [MAX_BYTES*8-1:0]         o_Acc_Bytes,
    output logic [len_w(MAX_BYTES)-1:0]    o_Acc_Len,
    output logic                           o_Err_Short,
    output logic                           o_Err_Ovf,
    output logic                           o_Err_Drop,
    output logic                           o_Err_Timeout
);

    localparam int unsigned LW = len_w(MAX_BYTES);
    localparam int unsigned AW = MAX_BYTES * 8;

    if (MAX_BYTES < 1 || MAX_BYTES > 16 || MIN_BYTES < 1 || MIN_BYTES > MAX_BYTES ||
        TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("spi_frame_acc: parameter out of range");
    end

    state_e        state_q, state_d;
    logic [LW-1:0] count_q, count_d;
    logic [AW-1:0] acc_q,   acc_d;
    logic          short_q, short_d;
    logic          ovf_q,   ovf_d;
    logic [AW+7:0] acc_wide;
    logic [AW-1:0] acc_shift;
    logic [AW-1:0] fin_acc;
    logic [LW-1:0] fin_count;
    logic          fin_lost;
    logic          pub_valid;

`ifdef SPI_ACC_TIMEOUT_EN
    localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_q, idle_d;
    logic          tmo_q,  tmo_d;
`endif

    // Truncating the widened concatenation keeps the shift legal for MAX_BYTES=1.
    assign acc_wide  = {acc_q, i_RX_Byte};
    assign acc_shift = acc_wide[AW-1:0];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        short_d   = 1'b0;
        ovf_d     = 1'b0;
        fin_acc   = acc_q;
        fin_count = count_q;
        fin_lost  = 1'b0;
        pub_valid = 1'b0;
`ifdef SPI_ACC_TIMEOUT_EN
        idle_d    = '0;
        tmo_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!i_CS_n) begin
                    state_d = ACTIVE;
                    count_d = '0;
                    acc_d   = '0;
                end
            end
            ACTIVE: begin
                if (i_CS_n) begin
                    // A byte arriving with the CS rise belongs to the frame.
                    if (i_RX_DV) begin
                        if (count_q == LW'(MAX_BYTES)) begin
                            ovf_d    = 1'b1;
                            fin_lost = 1'b1;
                        end else begin
                            fin_acc   = acc_shift;
                            fin_count = count_q + LW'(1);
                        end
                    end
                    if (!fin_lost && fin_count != '0) begin
                        if (fin_count < LW'(MIN_BYTES)) short_d   = 1'b1;
                        else                            pub_valid = 1'b1;
                    end
                    state_d = IDLE;
                    count_d = '0;
                    acc_d   = '0;
                end else if (i_RX_DV) begin
                    if (count_q == LW'(MAX_BYTES)) begin
                        ovf_d   = 1'b1;
                        state_d = DISCARD;
                        count_d = '0;
                        acc_d   = '0;
                    end else begin
                        acc_d   = acc_shift;
                        count_d = count_q + LW'(1);
                    end
                end
`ifdef SPI_ACC_TIMEOUT_EN
                else if (count_q != '0) begin
                    if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
                        tmo_d   = 1'b1;
                        state_d = DISCARD;
                        count_d = '0;
                        acc_d   = '0;
                    end else begin
                        idle_d  = idle_q + IW'(1);
                    end
                end
`endif
            end
            DISCARD: begin
                if (i_CS_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            short_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            short_q <= short_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef SPI_ACC_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_) begin
            idle_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            tmo_q  <= tmo_d;
        end
    end
    assign o_Err_Timeout = tmo_q;
`else
    assign o_Err_Timeout = 1'b0;
`endif

    spi_acc_out_reg #(
        .AW (AW),
        .LW (LW)
    ) u_out_reg (
        .clk         (clk),
        .rst_        (rst_),
        .pub_valid_i (pub_valid),
        .pub_bytes_i (fin_acc),
        .pub_len_i   (fin_count),
        .ready_i     (i_Acc_Ready),
        .valid_o     (o_Acc_DV),
        .bytes_o     (o_Acc_Bytes),
        .len_o       (o_Acc_Len),
        .drop_o      (o_Err_Drop)
    );

    assign o_Err_Short = short_q;
    assign o_Err_Ovf   = ovf_q;

endmodule

// File: tb/tb_spi_frame_acc.sv
// Directed self-checking bench for spi_frame_acc (MAX_BYTES=8, MIN_BYTES=2).
module tb_spi_frame_acc;

    logic        clk = 1'b0;
    logic        rst_;
    logic [7:0]  i_RX_Byte;
    logic        i_RX_DV;
    logic        i_CS_n;
    logic        o_Acc_DV;
    logic        i_Acc_Ready;
    logic [63:0] o_Acc_Bytes;
    logic [3:0]  o_Acc_Len;
    logic        o_Err_Short;
    logic        o_Err_Ovf;
    logic        o_Err_Drop;
    logic        o_Err_Timeout;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    spi_frame_acc #(
        .MAX_BYTES      (8),
        .MIN_BYTES      (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst_          (rst_),
        .i_RX_Byte     (i_RX_Byte),
        .i_RX_DV       (i_RX_DV),
        .i_CS_n        (i_CS_n),
        .o_Acc_DV      (o_Acc_DV),
        .i_Acc_Ready   (i_Acc_Ready),
        .o_Acc_Bytes   (o_Acc_Bytes),
        .o_Acc_Len     (o_Acc_Len),
        .o_Err_Short   (o_Err_Short),
        .o_Err_Ovf     (o_Err_Ovf),
        .o_Err_Drop    (o_Err_Drop),
        .o_Err_Timeout (o_Err_Timeout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        tick();
        i_RX_DV   = 1'b0;
    endtask

    task automatic accept();
        i_Acc_Ready = 1'b1;
        tick();
        i_Acc_Ready = 1'b0;
    endtask

    initial begin
        rst_ = 1'b0; i_CS_n = 1'b1; i_RX_DV = 1'b0; i_RX_Byte = '0; i_Acc_Ready = 1'b0;
        tick(); tick();
        chk("rst_dv", {63'd0, o_Acc_DV}, 64'd0);
        chk("rst_len", {60'd0, o_Acc_Len}, 64'd0);
        chk("rst_bytes", o_Acc_Bytes, 64'd0);
        rst_ = 1'b1;

        // Basic 3-byte frame, held until ready
        i_CS_n = 1'b0; tick();
        send(8'h11); send(8'h22); send(8'h33);
        i_CS_n = 1'b1; tick();
        chk("f1_dv", {63'd0, o_Acc_DV}, 64'd1);
        chk("f1_len", {60'd0, o_Acc_Len}, 64'd3);
        chk("f1_bytes", o_Acc_Bytes, 64'h0000_0000_0011_2233);
        tick(); tick(); tick();
        chk("f1_hold_dv", {63'd0, o_Acc_DV}, 64'd1);
        chk("f1_hold_bytes", o_Acc_Bytes, 64'h0000_0000_0011_2233);
        accept();
        chk("f1_accept_dv", {63'd0, o_Acc_DV}, 64'd0);

        // Overflow on 9th byte, then a normal 2-byte frame
        i_CS_n = 1'b0; tick();
        for (int i = 1; i <= 8; i++) send(8'(i));
        chk("ovf_before", {63'd0, o_Err_Ovf}, 64'd0);
        send(8'h09);
        chk("ovf_pulse", {63'd0, o_Err_Ovf}, 64'd1);
        tick();
        chk("ovf_clear", {63'd0, o_Err_Ovf}, 64'd0);
        i_CS_n = 1'b1; tick(); tick();
        chk("ovf_nopub", {63'd0, o_Acc_DV}, 64'd0);
        i_CS_n = 1'b0; tick();
        send(8'hA1); send(8'hB2);
        i_CS_n = 1'b1; tick();
        chk("f2_dv", {63'd0, o_Acc_DV}, 64'd1);
        chk("f2_len", {60'd0, o_Acc_Len}, 64'd2);
        chk("f2_bytes", o_Acc_Bytes, 64'h0000_0000_0000_A1B2);
        accept();

        // Short frame (MIN_BYTES=2)
        i_CS_n = 1'b0; tick();
        send(8'hAA);
        i_CS_n = 1'b1; tick();
        chk("short_pulse", {63'd0, o_Err_Short}, 64'd1);
        chk("short_nodv", {63'd0, o_Acc_DV}, 64'd0);
        tick();
        chk("short_clear", {63'd0, o_Err_Short}, 64'd0);

        // Back-to-back with ready low: second frame dropped
        i_CS_n = 1'b0; tick(); send(8'h01); send(8'h02); i_CS_n = 1'b1; tick();
        i_CS_n = 1'b0; tick(); send(8'h03); send(8'h04); i_CS_n = 1'b1; tick();
        chk("drop_pulse", {63'd0, o_Err_Drop}, 64'd1);
        chk("drop_keep", o_Acc_Bytes, 64'h0000_0000_0000_0102);
        chk("drop_dv", {63'd0, o_Acc_DV}, 64'd1);
        tick();
        chk("drop_clear", {63'd0, o_Err_Drop}, 64'd0);
        accept();
        chk("drop_accept_dv", {63'd0, o_Acc_DV}, 64'd0);

        // Back-to-back with ready in the publish cycle: second loads
        i_CS_n = 1'b0; tick(); send(8'h05); send(8'h06); i_CS_n = 1'b1; tick();
        i_CS_n = 1'b0; tick(); send(8'h07); send(8'h08); send(8'h09);
        i_CS_n = 1'b1; i_Acc_Ready = 1'b1; tick(); i_Acc_Ready = 1'b0;
        chk("swap_dv", {63'd0, o_Acc_DV}, 64'd1);
        chk("swap_bytes", o_Acc_Bytes, 64'h0000_0000_0007_0809);
        chk("swap_len", {60'd0, o_Acc_Len}, 64'd3);
        chk("swap_nodrop", {63'd0, o_Err_Drop}, 64'd0);
        accept();

        // Byte strobed together with CS rise is included
        i_CS_n = 1'b0; tick(); send(8'h5A);
        i_RX_DV = 1'b1; i_RX_Byte = 8'hC3; i_CS_n = 1'b1; tick(); i_RX_DV = 1'b0;
        chk("edge_len", {60'd0, o_Acc_Len}, 64'd2);
        chk("edge_bytes", o_Acc_Bytes, 64'h0000_0000_0000_5AC3);

        // Mid-frame reset with a frame still pending
        i_CS_n = 1'b0; tick(); send(8'h77); send(8'h88);
        rst_ = 1'b0; tick();
        chk("mrst_dv", {63'd0, o_Acc_DV}, 64'd0);
        chk("mrst_len", {60'd0, o_Acc_Len}, 64'd0);
        chk("mrst_bytes", o_Acc_Bytes, 64'd0);
        rst_ = 1'b1; tick();
        send(8'h99); send(8'h9A); i_CS_n = 1'b1; tick();
        chk("mrst_new_len", {60'd0, o_Acc_Len}, 64'd2);
        chk("mrst_new_bytes", o_Acc_Bytes, 64'h0000_0000_0000_999A);
        accept();

        // CS toggle with no bytes
        i_CS_n = 1'b0; tick(); i_CS_n = 1'b1; tick();
        chk("empty_dv", {63'd0, o_Acc_DV}, 64'd0);
        chk("empty_short", {63'd0, o_Err_Short}, 64'd0);
        tick();

`ifdef SPI_ACC_TIMEOUT_EN
        i_CS_n = 1'b0; tick(); send(8'h42);
        repeat (15) tick();
        chk("tmo_early", {63'd0, o_Err_Timeout}, 64'd0);
        tick();
        chk("tmo_pulse", {63'd0, o_Err_Timeout}, 64'd1);
        send(8'h43); send(8'h44);
        i_CS_n = 1'b1; tick(); tick();
        chk("tmo_nopub", {63'd0, o_Acc_DV}, 64'd0);
        chk("tmo_noshort", {63'd0, o_Err_Short}, 64'd0);
`else
        i_CS_n = 1'b0; tick(); send(8'h42);
        repeat (20) tick();
        chk("tmo_off", {63'd0, o_Err_Timeout}, 64'd0);
        i_CS_n = 1'b1; tick();
        chk("tmo_off_short", {63'd0, o_Err_Short}, 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
